// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  typedef logic [1:0] sa_state_t;

  localparam sa_state_t IDLE  = 2'b00;
  localparam sa_state_t SHIFT = 2'b01;
  localparam sa_state_t DONE  = 2'b10;

  localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
  input  logic X,
  input  logic Y,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = X ^ Y ^ Ci;
  assign Co = (X & Y) | (Ci & (X ^ Y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladder cell, LSB first, registered carry between bits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  sa_state_t        state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] s_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_s_s;
  logic             fa_co_s;
  logic [WIDTH-1:0] s_next_s;
  logic             accept_s;
  logic             last_s;

  fulladder u_fa (
    .X  (a_sr_r[0]),
    .Y  (b_sr_r[0]),
    .Ci (carry_r),
    .S  (fa_s_s),
    .Co (fa_co_s)
  );

  // Sum register shifts right with the new bit entering at the MSB.
  generate
    if (WIDTH == 1) begin : g_s_one
      assign s_next_s = fa_s_s;
    end else begin : g_s_many
      assign s_next_s = {fa_s_s, s_sr_r[WIDTH-1:1]};
    end
  endgenerate

  // Request acceptance and last-bit detection.
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    if (bus.start && ((state_r == IDLE) || (state_r == DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (cnt_r == CW'(WIDTH - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // FSM, operand/sum shift registers, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      s_sr_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        a_sr_r  <= bus.A;
        b_sr_r  <= bus.B;
        carry_r <= bus.Cin;
        s_sr_r  <= '0;
        cnt_r   <= '0;
        busy_r  <= 1'b1;
        state_r <= SHIFT;
      end else begin
        case (state_r)
          SHIFT: begin
            a_sr_r  <= a_sr_r >> 1'b1;
            b_sr_r  <= b_sr_r >> 1'b1;
            s_sr_r  <= s_next_s;
            carry_r <= fa_co_s;
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
              sum_r   <= s_next_s;
              cout_r  <= fa_co_s;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= DONE;
            end else begin
              state_r <= SHIFT;
            end
          end
          DONE: begin
            state_r <= IDLE;
          end
          IDLE: begin
            state_r <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = sum_r;
  assign bus.Cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance until done (bounded); report cycles taken and cycles busy was seen high.
  task automatic wait_done8(output int cyc, output int bc, output int both);
    cyc  = 0;
    bc   = 0;
    both = 0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      if (bus8.busy === 1'b1) bc++;
      if (bus8.busy === 1'b1 && bus8.done === 1'b1) both++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int bc;
    int both;
    int seen;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00; bus8.Cin = 1'b0;
    bus1.start = 1'b0; bus1.A = 1'b0;  bus1.B = 1'b0;  bus1.Cin = 1'b0;
    tick();
    tick();
    chk("reset_busy", {31'd0, bus8.busy}, 32'd0);
    chk("reset_done", {31'd0, bus8.done}, 32'd0);
    chk("reset_S", {24'd0, bus8.S}, 32'd0);
    chk("reset_Cout", {31'd0, bus8.Cout}, 32'd0);
    chk("reset_w1_S", {31'd0, bus1.S}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      bus8.start = 1'b1; bus8.A = vecs[i].a; bus8.B = vecs[i].b; bus8.Cin = vecs[i].cin;
      tick();
      bus8.start = 1'b0;
      wait_done8(cyc, bc, both);
      chk($sformatf("v%0d_latency", i), cyc, 32'd8);
      chk($sformatf("v%0d_busy_cycles", i), bc, 32'd8);
      chk($sformatf("v%0d_busy_done_overlap", i), both, 32'd0);
      chk($sformatf("v%0d_S", i), {24'd0, bus8.S}, {24'd0, vecs[i].s});
      chk($sformatf("v%0d_Cout", i), {31'd0, bus8.Cout}, {31'd0, vecs[i].cout});
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, bus8.busy}, 32'd0);
      tick();
      chk($sformatf("v%0d_done_pulse", i), {31'd0, bus8.done}, 32'd0);
      chk($sformatf("v%0d_S_hold", i), {24'd0, bus8.S}, {24'd0, vecs[i].s});
    end

    // start during SHIFT is ignored; previous S held while shifting.
    bus8.start = 1'b1; bus8.A = 8'h10; bus8.B = 8'h20; bus8.Cin = 1'b0;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    chk("ign_S_held_in_shift", {24'd0, bus8.S}, 32'h47);
    bus8.start = 1'b1; bus8.A = 8'h01; bus8.B = 8'h01;
    tick();
    bus8.start = 1'b0;
    wait_done8(cyc, bc, both);
    chk("ign_latency", cyc, 32'd5);
    chk("ign_S", {24'd0, bus8.S}, 32'h30);
    chk("ign_Cout", {31'd0, bus8.Cout}, 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
    end
    chk("ign_no_second_done", seen, 32'd0);

    // Reset in the middle of an operation abandons it.
    bus8.start = 1'b1; bus8.A = 8'h5A; bus8.B = 8'h33; bus8.Cin = 1'b0;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_S", {24'd0, bus8.S}, 32'd0);
    chk("rst_mid_Cout", {31'd0, bus8.Cout}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus8.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, bus8.done}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus8.done === 1'b1) seen++;
    end
    chk("rst_mid_no_done", seen, 32'd0);
    bus8.start = 1'b1; bus8.A = 8'h02; bus8.B = 8'h03;
    tick();
    bus8.start = 1'b0;
    wait_done8(cyc, bc, both);
    chk("post_rst_latency", cyc, 32'd8);
    chk("post_rst_S", {24'd0, bus8.S}, 32'h05);

    // Back-to-back: the DONE cycle accepts the next request.
    tick();
    bus8.start = 1'b1; bus8.A = 8'h01; bus8.B = 8'h02; bus8.Cin = 1'b0;
    tick();
    bus8.A = 8'h0F; bus8.B = 8'h01;
    wait_done8(cyc, bc, both);
    chk("b2b_first_latency", cyc, 32'd8);
    chk("b2b_first_S", {24'd0, bus8.S}, 32'h03);
    tick();
    bus8.start = 1'b0;
    chk("b2b_reaccept_busy", {31'd0, bus8.busy}, 32'd1);
    chk("b2b_reaccept_done_low", {31'd0, bus8.done}, 32'd0);
    chk("b2b_S_held", {24'd0, bus8.S}, 32'h03);
    wait_done8(cyc, bc, both);
    chk("b2b_second_latency", cyc, 32'd8);
    chk("b2b_second_S", {24'd0, bus8.S}, 32'h10);
    chk("b2b_second_Cout", {31'd0, bus8.Cout}, 32'd0);
    tick();

    // WIDTH=1: single SHIFT cycle.
    bus1.start = 1'b1; bus1.A = 1'b1; bus1.B = 1'b1; bus1.Cin = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("w1_busy", {31'd0, bus1.busy}, 32'd1);
    chk("w1_done_early", {31'd0, bus1.done}, 32'd0);
    tick();
    chk("w1_done", {31'd0, bus1.done}, 32'd1);
    chk("w1_busy_at_done", {31'd0, bus1.busy}, 32'd0);
    chk("w1_S", {31'd0, bus1.S}, 32'd1);
    chk("w1_Cout", {31'd0, bus1.Cout}, 32'd1);
    tick();
    chk("w1_done_pulse", {31'd0, bus1.done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
